quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_dec_pkg.sv | 26 ++
 rtl/quad_sync_filter.sv | 41 ++++
 rtl/quad_decoder.sv | 106 ++++++++++
 tb/tb_quad_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/quad_dec_pkg.sv
// Shared constants for the quadrature decoder: decoder states, direction
// encoding and the Gray-sequence neighbour tables used to classify steps.
package quad_dec_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } dec_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Packed per {A,B} index: entry i sits in bits [2*i+1:2*i].
    // Up sequence 00->01->11->10->00; the previous table is its reverse.
    localparam logic [7:0] GRAY_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};
    localparam logic [7:0] GRAY_PREV = {2'b01, 2'b11, 2'b00, 2'b10};

    function automatic logic [1:0] gray_next(input logic [1:0] pair);
        return GRAY_NEXT[{pair, 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] gray_prev(input logic [1:0] pair);
        return GRAY_PREV[{pair, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// One quadrature channel: SYNC_STAGES-deep synchronizer followed by a
// glitch filter that accepts a new level after FILT_LEN equal samples.
module quad_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic [3:0]             run_cnt;
    logic                   sync_lvl;

    assign sync_lvl = sync_p[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p  <= '0;
            run_cnt <= '0;
            filt    <= 1'b0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
            // run_cnt counts differing samples already seen; the current
            // one completes the run when the count reaches FILT_LEN-1.
            if (sync_lvl != filt) begin
                if (run_cnt == 4'(FILT_LEN - 1)) begin
                    filt    <= sync_lvl;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 4'd1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B pair to a modulo-16 position counter.
// Define QUAD_DECODER_ERR_EN to enable the sticky illegal-transition flag.
module quad_decoder
    import quad_dec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       err_clr,
    output logic [3:0] count,
    output logic       dir,
    output logic       step,
    output logic       err
);

    // INIT lasts until a level present at reset release has crossed the
    // whole synchronizer+filter pipeline, so that level becomes the
    // baseline pair instead of being decoded as a move away from 00.
    localparam logic [4:0] WARMUP = 5'(SYNC_STAGES + FILT_LEN);

    logic       a_filt, b_filt;
    logic [1:0] cur_pair, prev_pair;
    logic [4:0] init_cnt;
    logic       up, down, illegal;
    dec_state_t state, next_state;

    quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk (clk),
        .rst (rst),
        .raw (a_in),
        .filt(a_filt)
    );

    quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk (clk),
        .rst (rst),
        .raw (b_in),
        .filt(b_filt)
    );

    assign cur_pair = {a_filt, b_filt};

    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        up         = 1'b0;
        down       = 1'b0;
        illegal    = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_cnt == WARMUP) next_state = ST_TRACK;
            end
            ST_TRACK: begin
                if (cur_pair != prev_pair) begin
                    if (cur_pair == gray_next(prev_pair))      up      = 1'b1;
                    else if (cur_pair == gray_prev(prev_pair)) down    = 1'b1;
                    else                                       illegal = 1'b1;
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt  <= '0;
            prev_pair <= '0;
            count     <= '0;
            dir       <= DIR_DOWN;
            step      <= 1'b0;
        end else begin
            prev_pair <= cur_pair;
            step      <= up | down;
            if (state == ST_INIT && init_cnt != WARMUP) init_cnt <= init_cnt + 5'd1;
            if (up) begin
                count <= count + 4'd1;
                dir   <= DIR_UP;
            end else if (down) begin
                count <= count - 4'd1;
                dir   <= DIR_DOWN;
            end
        end
    end

`ifdef QUAD_DECODER_ERR_EN
    // A new illegal transition takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)          err <= 1'b0;
        else if (illegal) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end
`else
    logic unused_err_inputs;
    assign unused_err_inputs = err_clr ^ illegal;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Directed, table-driven bench for quad_decoder (default SYNC_STAGES=2,
// FILT_LEN=3, so a held input change shows up 6 rising edges later).
module tb_quad_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;
    localparam int LAT         = SYNC_STAGES + FILT_LEN + 1;
    localparam int HOLD        = 10;
`ifdef QUAD_DECODER_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, a_in, b_in, err_clr;
    logic [3:0] count;
    logic       dir, step, err;

    int errors = 0;
    int checks = 0;
    int step_total = 0;

    quad_decoder #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .a_in   (a_in),
        .b_in   (b_in),
        .err_clr(err_clr),
        .count  (count),
        .dir    (dir),
        .step   (step),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Counts cycles with step high, sampled on the falling edge.
    always @(negedge clk) if (step === 1'b1) step_total <= step_total + 1;

    typedef struct {
        logic       a;
        logic       b;
        logic [3:0] cnt;
        logic       dir;
        int         steps;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int cnt, input int d,
                            input int st, input int e);
        chk({name, ".count"}, int'(count), cnt);
        chk({name, ".dir"},   int'(dir),   d);
        chk({name, ".step"},  int'(step),  st);
        chk({name, ".err"},   int'(err),   e);
    endtask

    initial begin
        int snap;

        vecs[0] = '{a: 1'b0, b: 1'b1, cnt: 4'h1, dir: 1'b1, steps: 1};
        vecs[1] = '{a: 1'b1, b: 1'b1, cnt: 4'h2, dir: 1'b1, steps: 1};
        vecs[2] = '{a: 1'b1, b: 1'b0, cnt: 4'h3, dir: 1'b1, steps: 1};
        vecs[3] = '{a: 1'b0, b: 1'b0, cnt: 4'h4, dir: 1'b1, steps: 1};
        vecs[4] = '{a: 1'b1, b: 1'b0, cnt: 4'h3, dir: 1'b0, steps: 1};
        vecs[5] = '{a: 1'b1, b: 1'b1, cnt: 4'h2, dir: 1'b0, steps: 1};
        vecs[6] = '{a: 1'b0, b: 1'b1, cnt: 4'h1, dir: 1'b0, steps: 1};
        vecs[7] = '{a: 1'b0, b: 1'b0, cnt: 4'h0, dir: 1'b0, steps: 1};
        vecs[8] = '{a: 1'b1, b: 1'b0, cnt: 4'hF, dir: 1'b0, steps: 1};
        vecs[9] = '{a: 1'b0, b: 1'b0, cnt: 4'h0, dir: 1'b1, steps: 1};

        rst = 1'b1; a_in = 1'b0; b_in = 1'b0; err_clr = 1'b0;
        tick(3);
        chk_outs("reset", 0, 0, 0, 0);
        rst = 1'b0;
        snap = step_total;
        tick(12);
        chk("warmup.steps", step_total - snap, 0);
        chk_outs("warmup", 0, 0, 0, 0);

        // Full up cycle, full down cycle, then both wrap directions.
        for (int i = 0; i < 10; i++) begin
            a_in = vecs[i].a;
            b_in = vecs[i].b;
            snap = step_total;
            tick(HOLD);
            chk($sformatf("vec%0d.count", i), int'(count), int'(vecs[i].cnt));
            chk($sformatf("vec%0d.dir", i),   int'(dir),   int'(vecs[i].dir));
            chk($sformatf("vec%0d.steps", i), step_total - snap, vecs[i].steps);
            chk($sformatf("vec%0d.err", i),   int'(err),   0);
        end

        // Exact latency and single-cycle step pulse.
        b_in = 1'b1;
        tick(LAT - 1);
        chk("lat.early_count", int'(count), 0);
        chk("lat.early_step",  int'(step),  0);
        tick(1);
        chk("lat.count", int'(count), 1);
        chk("lat.step",  int'(step),  1);
        tick(1);
        chk("lat.step_drop", int'(step), 0);
        b_in = 1'b0;
        tick(HOLD);
        chk("back.count", int'(count), 0);
        chk("back.dir",   int'(dir),   0);

        // Glitch of FILT_LEN-1 samples is swallowed.
        snap = step_total;
        a_in = 1'b1;
        tick(FILT_LEN - 1);
        a_in = 1'b0;
        tick(12);
        chk("glitch.steps", step_total - snap, 0);
        chk_outs("glitch", 0, 0, 0, 0);

        // Illegal 00->11, then clear racing a second illegal, then clear alone.
        snap = step_total;
        a_in = 1'b1; b_in = 1'b1;
        tick(HOLD);
        chk("ill1.steps", step_total - snap, 0);
        chk_outs("ill1", 0, 0, 0, int'(ERR_EN));
        a_in = 1'b0; b_in = 1'b0;
        tick(LAT - 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ill2.err_set_wins", int'(err), int'(ERR_EN));
        tick(4);
        chk("ill2.steps", step_total - snap, 0);
        chk("ill2.count", int'(count), 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("clr.err", int'(err), 0);
        tick(2);

        // Reset released with both inputs high: no step, no err.
        rst = 1'b1; a_in = 1'b1; b_in = 1'b1;
        tick(3);
        rst = 1'b0;
        snap = step_total;
        tick(15);
        chk("start11.steps", step_total - snap, 0);
        chk_outs("start11", 0, 0, 0, 0);
        b_in = 1'b0;
        tick(HOLD);
        chk("start11.up_steps", step_total - snap, 1);
        chk_outs("start11.up", 1, 1, 0, 0);

        // Reset one cycle before a pending 10->00 step would emerge.
        a_in = 1'b0;
        snap = step_total;
        tick(LAT - 1);
        rst = 1'b1;
        tick(1);
        chk_outs("midrst", 0, 0, 0, 0);
        rst = 1'b0;
        tick(15);
        chk("midrst.steps", step_total - snap, 0);
        chk_outs("midrst.after", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

endmodule
